// File: rtl/gfx256_pkg.sv
// gfx256_pkg: shared colour-depth encoding, reader states and bits-per-pixel lookup
package gfx256_pkg;
    typedef enum logic [1:0] {CD_8 = 2'b00, CD_16 = 2'b01, CD_32 = 2'b10, CD_32B = 2'b11} color_depth_e;
    typedef enum logic [2:0] {IDLE, CALC1, CALC2, READ_PIX, READ_Z, DONE} state_e;
    function automatic logic [5:0] bpp_of(input logic [1:0] cd);
        return cd == CD_8 ? 6'd8 : cd == CD_16 ? 6'd16 : 6'd32;
    endfunction
endpackage

// File: rtl/gfx256_pixel_reader_if.sv
// gfx256_pixel_reader_if: 256-bit memory read bus between the pixel reader and memory
// Signals: read_o request, read_addr_o 32-byte-aligned address, read_sel_o byte lanes,
// read_dat_i returned word, read_ack_i acknowledge.
interface gfx256_pixel_reader_if;
    logic         read_o;
    logic [31:0]  read_addr_o;
    logic [31:0]  read_sel_o;
    logic [255:0] read_dat_i;
    logic         read_ack_i;
    modport master (output read_o, read_addr_o, read_sel_o, input read_dat_i, read_ack_i);
    modport slave  (input read_o, read_addr_o, read_sel_o, output read_dat_i, read_ack_i);
endinterface

// File: rtl/gfx256_memory_to_color.sv
// gfx256_memory_to_color: picks byte lanes and extracts one pixel from a 256-bit memory word
// Ports: dat_i memory word, mb_i bit offset in the word, bpp_i bits per pixel,
// sel_o byte lanes covered by the pixel, color_o zero-extended pixel value.
module gfx256_memory_to_color (
    input  logic [255:0] dat_i,
    input  logic [7:0]   mb_i,
    input  logic [5:0]   bpp_i,
    output logic [31:0]  sel_o,
    output logic [31:0]  color_o
);
    // bpp_i = 0 (the reset value in the reader) yields no lanes and a zero pixel
    always_comb begin
        sel_o   = 32'((33'h1 << (bpp_i >> 3)) - 33'h1) << mb_i[7:3];
        color_o = 32'(dat_i >> mb_i) & 32'((33'h1 << bpp_i) - 33'h1);
    end
endmodule

// File: rtl/gfx256_pixel_reader.sv
// gfx256_pixel_reader: reads one pixel and optionally its 16-bit depth from 256-bit memory
// Ports: clk_i clock, rst_ni sync active-low reset; target/zbuffer bases and buffer size;
// color_depth_i format; pixel_x_i/pixel_y_i/zbuffer_enable_i/read_i request;
// mem memory read master; busy_o, color_o, z_o, oob_o, ack_o results.
module gfx256_pixel_reader
    import gfx256_pkg::*;
#(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            target_base_i,
    input  logic [31:0]            zbuffer_base_i,
    input  logic [point_width-1:0] target_size_x_i,
    input  logic [point_width-1:0] target_size_y_i,
    input  logic [1:0]             color_depth_i,
    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic                   zbuffer_enable_i,
    input  logic                   read_i,
    output logic                   busy_o,
    gfx256_pixel_reader_if.master  mem,
    output logic [31:0]            color_o,
    output logic [15:0]            z_o,
    output logic                   oob_o,
    output logic                   ack_o
);
    state_e                 state_q, state_d;
    logic [point_width-1:0] x_q, x_d, y_q, y_d;
    logic                   zen_q, zen_d, read_q, read_d, oob_q, oob_d, oob;
    logic [1:0]             cd_q, cd_d;
    logic [31:0]            base_q, base_d, zbase_q, zbase_d, index_q, index_d;
    logic [31:0]            addr_q, addr_d, zaddr_q, zaddr_d, color_q, color_d;
    logic [7:0]             mb_q, mb_d, zmb_q, zmb_d;
    logic [5:0]             bpp_q, bpp_d, bpp;
    logic [15:0]            z_q, z_d;
    logic [31:0]            pix_bit, zbit, sel, pix;

    gfx256_memory_to_color u_m2c (
        .dat_i   (mem.read_dat_i),
        .mb_i    (mb_q),
        .bpp_i   (bpp_q),
        .sel_o   (sel),
        .color_o (pix)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q <= '0; y_q <= '0; zen_q <= 1'b0; cd_q <= '0; base_q <= '0; zbase_q <= '0;
            index_q <= '0; addr_q <= '0; zaddr_q <= '0; mb_q <= '0; zmb_q <= '0; bpp_q <= '0;
            read_q <= 1'b0; oob_q <= 1'b0; color_q <= '0; z_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d; y_q <= y_d; zen_q <= zen_d; cd_q <= cd_d; base_q <= base_d; zbase_q <= zbase_d;
            index_q <= index_d; addr_q <= addr_d; zaddr_q <= zaddr_d; mb_q <= mb_d; zmb_q <= zmb_d; bpp_q <= bpp_d;
            read_q <= read_d; oob_q <= oob_d; color_q <= color_d; z_q <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d = x_q; y_d = y_q; zen_d = zen_q; cd_d = cd_q; base_d = base_q; zbase_d = zbase_q;
        index_d = index_q; addr_d = addr_q; zaddr_d = zaddr_q; mb_d = mb_q; zmb_d = zmb_q; bpp_d = bpp_q;
        read_d = read_q; oob_d = oob_q; color_d = color_q; z_d = z_q;
        bpp     = bpp_of(cd_q);
        pix_bit = index_q * 32'(bpp);
        zbit    = {index_q[27:0], 4'h0};
        oob     = x_q >= target_size_x_i || y_q >= target_size_y_i;
        case (state_q)
            IDLE: if (read_i) begin
                state_d = CALC1;
                x_d = pixel_x_i; y_d = pixel_y_i; zen_d = zbuffer_enable_i; cd_d = color_depth_i;
                base_d = target_base_i; zbase_d = zbuffer_base_i;
                color_d = '0; z_d = '0; oob_d = 1'b0;
            end
            CALC1: begin
                index_d = 32'(y_q) * 32'(target_size_x_i) + 32'(x_q);
                state_d = CALC2;
            end
            CALC2: begin
                // both addresses are resolved here so READ_Z only has to swap them in
                addr_d  = base_q + {3'b0, pix_bit[31:8], 5'b0};
                mb_d    = pix_bit[7:0];
                bpp_d   = bpp;
                zaddr_d = zbase_q + {3'b0, zbit[31:8], 5'b0};
                zmb_d   = zbit[7:0];
                oob_d   = oob;
                read_d  = !oob;
                state_d = oob ? DONE : READ_PIX;
            end
            READ_PIX: if (read_q && mem.read_ack_i) begin
                color_d = pix;
                read_d  = 1'b0;
                state_d = zen_q ? READ_Z : DONE;
                addr_d  = zen_q ? zaddr_q : addr_q;
                mb_d    = zen_q ? zmb_q : mb_q;
                bpp_d   = zen_q ? 6'd16 : bpp_q;
            end
            // read_q arrives low from the pixel ack, giving one idle bus cycle before the depth read
            READ_Z: begin
                read_d = !(read_q && mem.read_ack_i);
                if (read_q && mem.read_ack_i) begin
                    z_d     = pix[15:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o          = state_q != IDLE;
    assign ack_o           = state_q == DONE;
    assign mem.read_o      = read_q;
    assign mem.read_addr_o = addr_q;
    assign mem.read_sel_o  = sel;
    assign color_o         = color_q;
    assign z_o             = z_q;
    assign oob_o           = oob_q;
endmodule

// File: tb/tb_gfx256_pixel_reader.sv
// tb_gfx256_pixel_reader: table, directed and randomized checks of gfx256_pixel_reader against a reference model
module tb_gfx256_pixel_reader;
    typedef struct {
        logic [31:0] base, zbase;
        logic [15:0] sx, sy, x, y;
        logic [1:0]  cd;
        logic        zen;
        int          dly;
        logic        e_oob;
        logic [31:0] e_addr, e_sel, e_color, e_zaddr, e_zsel;
        logic [15:0] e_z;
    } vec_t;

    logic clk = 1'b0, rst_ni = 1'b0;
    logic [31:0] target_base, zbuffer_base, color;
    logic [15:0] size_x, size_y, pixel_x, pixel_y, z;
    logic [1:0] color_depth;
    logic zen, read_i, busy, oob, ack, ack_r;
    int checks = 0, errors = 0, cyc = 0, t0 = 0;
    int ack_delay = 0, ack_limit = 1000, wcnt = 0;
    logic force_ack = 1'b0, fixed_mode = 1'b1, was_hi = 1'b0, unstable = 1'b0;
    logic [255:0] fixed_dat;
    logic [31:0] hold_addr, hold_sel;
    logic [31:0] rd_addr[$], rd_sel[$];
    int rise_q[$], ackc_q[$];
    vec_t tbl[7];

    gfx256_pixel_reader_if bus();

    gfx256_pixel_reader #(.point_width(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .target_base_i(target_base), .zbuffer_base_i(zbuffer_base),
        .target_size_x_i(size_x), .target_size_y_i(size_y),
        .color_depth_i(color_depth), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
        .zbuffer_enable_i(zen), .read_i(read_i), .busy_o(busy), .mem(bus),
        .color_o(color), .z_o(z), .oob_o(oob), .ack_o(ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [255:0] memdat(input logic [31:0] a);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = (a * 32'h9E3779B1) ^ ((k + 1) * 32'h85EBCA6B);
        return fixed_mode ? fixed_dat : w;
    endfunction

    // memory: acks after ack_delay cycles of read_o, logs every accepted read
    always @(negedge clk) begin
        ack_r = 1'b0;
        if (bus.read_o) begin
            if (!was_hi) begin
                rise_q.push_back(cyc);
                hold_addr = bus.read_addr_o;
                hold_sel = bus.read_sel_o;
                wcnt = 0;
            end else if (bus.read_addr_o !== hold_addr || bus.read_sel_o !== hold_sel) unstable = 1'b1;
            if (wcnt >= ack_delay && rd_addr.size() < ack_limit) begin
                ack_r = 1'b1;
                rd_addr.push_back(bus.read_addr_o);
                rd_sel.push_back(bus.read_sel_o);
                ackc_q.push_back(cyc);
            end
            wcnt++;
        end
        was_hi = bus.read_o;
        bus.read_ack_i = ack_r | force_ack;
        bus.read_dat_i = ack_r ? memdat(bus.read_addr_o) : ~memdat(bus.read_addr_o);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference: pixel index -> bit position -> 32-byte word address and lane range
    function automatic vec_t model(input vec_t v);
        int unsigned bpp, idx, bp, zb;
        logic [255:0] w;
        bpp = v.cd == 2'd0 ? 8 : v.cd == 2'd1 ? 16 : 32;
        v.e_oob = v.x >= v.sx || v.y >= v.sy;
        {v.e_addr, v.e_sel, v.e_color, v.e_zaddr, v.e_zsel, v.e_z} = '0;
        if (!v.e_oob) begin
            idx = v.y * v.sx + v.x;
            bp = idx * bpp;
            v.e_addr = v.base + bp / 256 * 32;
            w = memdat(v.e_addr) >> (bp % 256);
            v.e_color = 32'(w[31:0] % (64'h1 << bpp));
            for (int b = 0; b < bpp / 8; b++) v.e_sel[(bp % 256) / 8 + b] = 1'b1;
            if (v.zen) begin
                zb = idx * 16;
                v.e_zaddr = v.zbase + zb / 256 * 32;
                w = memdat(v.e_zaddr) >> (zb % 256);
                v.e_z = w[15:0];
                for (int b = 0; b < 2; b++) v.e_zsel[(zb % 256) / 8 + b] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic start(input vec_t v);
        target_base = v.base; zbuffer_base = v.zbase; size_x = v.sx; size_y = v.sy;
        color_depth = v.cd; pixel_x = v.x; pixel_y = v.y; zen = v.zen; ack_delay = v.dly;
        rd_addr.delete(); rd_sel.delete(); rise_q.delete(); ackc_q.delete(); unstable = 1'b0;
        read_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        read_i = 1'b0;
    endtask

    task automatic run_txn(input string nm, input vec_t v);
        int n, nexp;
        start(v);
        chk({nm, " busy"}, busy, 1);
        n = 0;
        while (!ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ack_seen"}, ack, 1);
        nexp = v.e_oob ? 0 : (v.zen ? 2 : 1);
        chk({nm, " nreads"}, rd_addr.size(), nexp);
        chk({nm, " oob"}, oob, v.e_oob);
        chk({nm, " color"}, color, v.e_color);
        chk({nm, " z"}, z, v.e_z);
        chk({nm, " stable"}, unstable, 0);
        if (nexp == 0) chk({nm, " oob_lat"}, cyc - t0, 3);
        if (nexp > 0 && rd_addr.size() == nexp) begin
            chk({nm, " addr"}, rd_addr[0], v.e_addr);
            chk({nm, " sel"}, rd_sel[0], v.e_sel);
            chk({nm, " read_lat"}, rise_q[0] - t0, 3);
            chk({nm, " ack_lat"}, cyc - ackc_q[nexp-1], 1);
            if (nexp == 2) begin
                chk({nm, " zaddr"}, rd_addr[1], v.e_zaddr);
                chk({nm, " zsel"}, rd_sel[1], v.e_zsel);
                chk({nm, " gap"}, rise_q[1] > ackc_q[0] + 1, 1);
            end
        end
        @(negedge clk);
        chk({nm, " ack_pulse"}, ack, 0);
        chk({nm, " idle"}, busy, 0);
        chk({nm, " color_hold"}, color, v.e_color);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int n, acks, busy_seen;
        for (int i = 0; i < 32; i++) fixed_dat[i*8 +: 8] = 8'hA2 + 8'(i);
        //          base      zbase      sx   sy   x    y   cd  zen dly oob addr       sel         color         zaddr      zsel    z
        tbl[0] = '{32'h1000, 32'h0,     640, 480, 20,  1,  1,  0,  2,  0,  32'h1520, 32'h300,    32'hABAA,     32'h0,     32'h0,  16'h0};
        tbl[1] = '{32'h0,    32'h0,     640, 480, 3,   0,  0,  0,  1,  0,  32'h0,    32'h8,      32'hA5,       32'h0,     32'h0,  16'h0};
        tbl[2] = '{32'h1000, 32'h20000, 640, 480, 20,  1,  1,  1,  1,  0,  32'h1520, 32'h300,    32'hABAA,     32'h20520, 32'h300, 16'hABAA};
        tbl[3] = '{32'h1000, 32'h20000, 640, 480, 640, 1,  1,  1,  0,  1,  32'h0,    32'h0,      32'h0,        32'h0,     32'h0,  16'h0};
        tbl[4] = '{32'h100,  32'h0,     100, 50,  5,   2,  2,  0,  0,  0,  32'h420,  32'hF00000, 32'hB9B8B7B6, 32'h0,     32'h0,  16'h0};
        tbl[5] = '{32'h0,    32'h0,     640, 480, 0,   480, 1, 0,  0,  1,  32'h0,    32'h0,      32'h0,        32'h0,     32'h0,  16'h0};
        tbl[6] = '{32'h40,   32'h8000,  640, 480, 0,   0,  3,  1,  0,  0,  32'h40,   32'hF,      32'hA5A4A3A2, 32'h8000,  32'h3,  16'hA3A2};
        read_i = 1'b0; zen = 1'b0; color_depth = '0; pixel_x = '0; pixel_y = '0;
        target_base = '0; zbuffer_base = '0; size_x = '0; size_y = '0;
        repeat (3) @(negedge clk);
        chk("rst read_o", bus.read_o, 0);
        chk("rst ack_o", ack, 0);
        chk("rst busy", busy, 0);
        chk("rst oob", oob, 0);
        chk("rst addr", bus.read_addr_o, 0);
        chk("rst sel", bus.read_sel_o, 0);
        chk("rst color", color, 0);
        chk("rst z", z, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // read_i pulsed while the pixel read is outstanding
        v = tbl[0];
        v.dly = 4;
        start(v);
        n = 0;
        while (!bus.read_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("busyread read_o", bus.read_o, 1);
        pixel_x = 16'd7;
        read_i = 1'b1;
        @(negedge clk);
        read_i = 1'b0;
        acks = 0;
        repeat (20) begin
            acks += int'(ack);
            @(negedge clk);
        end
        chk("busyread acks", acks, 1);
        chk("busyread nreads", rd_addr.size(), 1);
        chk("busyread color", color, 32'hABAA);

        // reset while the depth read is outstanding, then a stray ack
        ack_limit = 1;
        start(tbl[2]);
        n = 0;
        while (!(bus.read_o && rise_q.size() == 2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort z read_o", bus.read_o, 1);
        chk("abort color", color, 32'hABAA);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("abort read_o", bus.read_o, 0);
        chk("abort busy", busy, 0);
        chk("abort ack_o", ack, 0);
        chk("abort color_rst", color, 0);
        chk("abort addr", bus.read_addr_o, 0);
        chk("abort sel", bus.read_sel_o, 0);
        rst_ni = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        acks = 0;
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(ack);
            busy_seen += int'(busy);
        end
        chk("abort late acks", acks, 0);
        chk("abort late busy", busy_seen, 0);
        chk("abort late read_o", bus.read_o, 0);
        ack_limit = 1000;

        fixed_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v.sx = 16'($urandom_range(1, 300));
            v.sy = 16'($urandom_range(1, 300));
            v.x = 16'($urandom_range(0, v.sx + v.sx / 6));
            v.y = 16'($urandom_range(0, v.sy + v.sy / 6));
            v.cd = 2'($urandom_range(0, 3));
            v.zen = 1'($urandom_range(0, 1));
            v.base = $urandom & 32'hFFFFFFE0;
            v.zbase = $urandom & 32'hFFFFFFE0;
            v.dly = $urandom_range(0, 3);
            run_txn($sformatf("rnd%0d", i), model(v));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gfx256_pixel_reader.md
GFX256_PIXEL_READER -- requirements
Module: gfx256_pixel_reader

Interface
REQ-001 SHALL have parameter point_width, default 16, giving the coordinate and size width in bits.
REQ-002 SHALL have port clk_i  input  1  the single clock.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports target_base_i / zbuffer_base_i  input  32 each  byte base addresses of the colour and depth buffers.
REQ-005 SHALL have ports target_size_x_i / target_size_y_i  input  point_width each  buffer width and height in pixels.
REQ-006 SHALL have port color_depth_i  input  2  pixel format: 00 = 8 bpp, 01 = 16 bpp, 10 and 11 = 32 bpp.
REQ-007 SHALL have ports pixel_x_i / pixel_y_i  input  point_width each  pixel to read.
REQ-008 SHALL have port zbuffer_enable_i  input  1  also read the 16-bit depth value.
REQ-009 SHALL have port read_i  input  1  request strobe.
REQ-010 SHALL have port busy_o  output  1  high when not IDLE.
REQ-011 SHALL have port read_o  output  1  memory read request.
REQ-012 SHALL have port read_addr_o  output  32  32-byte-aligned byte address.
REQ-013 SHALL have port read_sel_o  output  32  byte lanes of the requested pixel.
REQ-014 SHALL have port read_dat_i  input  256  memory read data.
REQ-015 SHALL have port read_ack_i  input  1  memory acknowledge.
REQ-016 SHALL have ports color_o  output  32  and z_o  output  16  zero-extended results.
REQ-017 SHALL have ports oob_o  output  1  and ack_o  output  1  out-of-bounds flag and completion pulse.

Function
REQ-018 SHALL accept read_i only in IDLE, latching x, y, zbuffer_enable, color depth and both bases; read_i outside IDLE SHALL be ignored.
REQ-019 SHALL run states IDLE, CALC1, CALC2, READ_PIX, READ_Z, DONE.
- IDLE->CALC1 on read_i.
- CALC1->CALC2 unconditionally.
- CALC2->READ_PIX when in bounds, else DONE.
- READ_PIX->READ_Z on ack if z is enabled, else DONE.
- READ_Z->DONE on ack.
- DONE->IDLE.
REQ-020 SHALL compute index = y*size_x + x in CALC1, then bit = index*bpp, read_addr = base + (bit>>8)*32 and mb = bit[7:0] in CALC2, using at least 32-bit intermediates.
REQ-021 SHALL raise oob_o and skip all memory access when x >= size_x or y >= size_y.
REQ-022 SHALL assert read_o registered on entry to READ_PIX, hold it and the address and select stable until read_ack_i, and deassert it on the cycle after the ack.
REQ-023 SHALL sample read_ack_i only while read_o = 1.
REQ-024 SHALL set read_sel_o to the bpp/8 consecutive byte lanes starting at lane mb/8.
REQ-025 SHALL capture color_o from read_dat_i[mb +: bpp], zero-extended, on the ack cycle.
REQ-026 SHALL read depth in READ_Z at zbuffer_base with bpp = 16 and capture z_o from read_dat_i[zmb +: 16] on the ack cycle.
REQ-027 SHALL leave read_o low for at least one cycle between the pixel read and the depth read.
REQ-028 SHALL pulse ack_o for exactly one cycle in DONE; color_o, z_o and oob_o SHALL hold until the next accepted request.
- Accepting a request clears oob_o.
- An out-of-bounds request yields color_o = 0 and z_o = 0.
REQ-029 SHALL give a minimum latency of read_i at cycle 0, read_o at cycle 3 and ack_o one cycle after the final read_ack_i.
REQ-030 SHALL treat a read_ack_i in the same cycle as read_o first rises as valid.

Reset
REQ-031 SHALL, while rst_ni = 0 at a clock edge, enter IDLE and drive read_o, ack_o, busy_o, oob_o = 0, read_addr_o, read_sel_o = 0, color_o = 0 and z_o = 0.
REQ-032 SHALL, on reset mid-transaction, drop read_o on the next edge, produce no ack_o, and ignore any later read_ack_i for the aborted access.

Structure
REQ-033 SHALL take the colour-depth encoding and the bpp lookup function from gfx256_pkg.
REQ-034 SHALL place lane-select and bit extraction in one combinational sub-module, gfx256_memory_to_color, the inverse of the colour-to-memory packer.

Verification
REQ-035 SHALL cover: base 0x1000, width 640, 16 bpp, x = 20, y = 1 -> read_addr 0x1520, sel 0x00000300, color_o = dat[79:64], ack_o 1 cycle after ack.
REQ-036 SHALL cover: base 0, 8 bpp, x = 3, y = 0, dat byte 3 = 0xA5 -> addr 0x0, sel 0x8, color_o 0x000000A5.
REQ-037 SHALL cover: REQ-035 case with z enabled, zbuffer_base 0x20000 -> second read at 0x20520, sel 0x300, z_o = dat[79:64], read_o low at least 1 cycle between the reads.
REQ-038 SHALL cover: x = 640, width 640 -> no read_o, oob_o = 1, color_o = 0, ack_o at cycle 3.
REQ-039 SHALL cover: read_i pulsed during READ_PIX -> ignored, exactly one ack_o.
REQ-040 SHALL cover: rst_ni low while read_o is high, then a late read_ack_i -> outputs reset, no ack_o, state stays IDLE.
